ariscv_aclk_sched: RTL and testbench
====================================

ARISCV_ACLK_SCHED -- requirements
Module: ariscv_aclk_sched

Interface
REQ-001 SHALL have parameter ACLK_NBW, default 6, meaning the number of pipeline stages (local clock domains) sequenced.
REQ-002 SHALL have parameter DLY_NBW, default 4, meaning the width of the settle-delay input.
REQ-003 SHALL have parameter TO_NBW, default 8, meaning the width of the timeout counter (timeout = 2^TO_NBW-1 cycles).
REQ-004 SHALL have one clock and a synchronous, active-high reset, as already decided.
REQ-005 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: begin sequencing from IDLE.
REQ-008 SHALL have port i_halt, input, 1 bit: stop after the current stage completes.
REQ-009 SHALL have port i_dly, input, DLY_NBW bits: settle cycles between a stage's done and the next fire.
REQ-010 SHALL have port i_done, input, ACLK_NBW bits: per-stage completion, level-sampled.
REQ-011 SHALL have port o_fire, output, ACLK_NBW bits: one-hot, one-cycle stage-fire pulse.
REQ-012 SHALL have port o_stage, output, $clog2(ACLK_NBW) bits: current stage index.
REQ-013 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port o_wrap, output, 1 bit: one-cycle pulse when the sequence wraps to stage 0.
REQ-015 SHALL have port o_err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, FIRE, WAIT, SETTLE.
REQ-017 IDLE: i_start=1 and i_halt=0 SHALL go to FIRE with stage=0; i_start and i_halt both high SHALL stay in IDLE.
REQ-018 FIRE SHALL last exactly one cycle, drive o_fire = 1<<stage (registered Moore output), then go to WAIT; o_fire SHALL be zero in all other states.
REQ-019 Latency: i_start high at edge t SHALL give o_fire[0] high in cycle t+1.
REQ-020 WAIT SHALL sample only i_done[stage]; other i_done bits and any done in the FIRE cycle SHALL be ignored.
REQ-021 On done in WAIT: i_dly=0 SHALL advance directly; i_dly=N>0 SHALL enter SETTLE, capture N, and remain there exactly N cycles.
REQ-022 Advance: stage SHALL increment, wrap ACLK_NBW-1 -> 0, and go to FIRE; done seen at edge d SHALL give the next fire in cycle d+1+N.
REQ-023 o_wrap SHALL pulse in the FIRE cycle of stage 0 reached by wrap-around, never on the initial start.
REQ-024 i_halt high in any non-IDLE state SHALL set a pending-halt latch; at the advance point, pending halt SHALL go to IDLE (stage -> 0, latch cleared) instead of FIRE.
REQ-025 o_err SHALL clear on i_start accepted in IDLE.

Reset
REQ-026 rst=1 at any edge, including mid-sequence, SHALL force IDLE, stage=0, counters=0, pending halt=0, and o_fire=0, o_stage=0, o_busy=0, o_wrap=0, o_err=0 in the following cycle.
REQ-027 Reset SHALL take priority over i_start, i_halt and i_done.

Configuration
REQ-028 Macro ARISCV_SCHED_TIMEOUT_EN defined: a WAIT lasting 2^TO_NBW-1 cycles without done SHALL set o_err and advance as if done with i_dly=0, so pending halt still applies.
REQ-029 Macro ARISCV_SCHED_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, o_err SHALL be constant 0, and no timeout counter SHALL be synthesized.

Structure
REQ-030 Package ariscv_pkg SHALL hold the state typedef ariscv_sched_state_t and the default ACLK_NBW constant.
REQ-031 Sub-module ariscv_sched_cnt SHALL be a loadable down-counter with a zero flag, shared for settle and timeout.

Verification
REQ-032 Bench SHALL check: rst then i_start at t -> o_fire=6'b000001 at t+1, o_busy=1, o_stage=0.
REQ-033 Bench SHALL check: i_dly=3, i_done[0] at d -> o_fire=6'b000010 at d+4 and o_fire=0 in between.
REQ-034 Bench SHALL check: six stages completed with i_dly=0 -> o_fire=6'b000001 again with o_wrap=1 for that one cycle.
REQ-035 Bench SHALL check: i_halt pulsed during WAIT of stage 2, then i_done[2] -> IDLE, o_busy=0, o_stage=0, no further fire; a done on a non-current stage SHALL produce no advance.
REQ-036 Bench SHALL check: with ARISCV_SCHED_TIMEOUT_EN and TO_NBW=4, no done -> o_err=1 after 15 WAIT cycles and stage advances; rst mid-WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ariscv_pkg.sv
// Shared types for the local-clock stage scheduler.
// Holds the FSM state encoding and default stage count.
package ariscv_pkg;

  localparam int ARISCV_ACLK_NBW = 6;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_SETTLE
  } ariscv_sched_state_t;

endpackage

// File: rtl/ariscv_aclk_sched_if.sv
// Control/status bundle for the stage scheduler.
// master drives requests and done levels, slave drives fire/status.
interface ariscv_aclk_sched_if
  import ariscv_pkg::*;
#(
  parameter int ACLK_NBW = ARISCV_ACLK_NBW,
  parameter int DLY_NBW  = 4
);
  logic                        start;
  logic                        halt;
  logic [DLY_NBW-1:0]          dly;
  logic [ACLK_NBW-1:0]         done;
  logic [ACLK_NBW-1:0]         fire;
  logic [$clog2(ACLK_NBW)-1:0] stage;
  logic                        busy;
  logic                        wrap;
  logic                        err;

  modport master (
    output start, halt, dly, done,
    input  fire, stage, busy, wrap, err
  );

  modport slave (
    input  start, halt, dly, done,
    output fire, stage, busy, wrap, err
  );
endinterface

// File: rtl/ariscv_sched_cnt.sv
// Loadable down-counter with zero flag.
// Shared by the settle delay and the WAIT timeout.
module ariscv_sched_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // load wins over decrement; decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_val;
    end else if (i_dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_zero = (cnt_q == '0);
endmodule

// File: rtl/ariscv_aclk_sched.sv
// Sequences local clock domains: fire, wait done, settle, advance.
// Optional WAIT timeout with sticky error: ARISCV_SCHED_TIMEOUT_EN.
module ariscv_aclk_sched
  import ariscv_pkg::*;
#(
  parameter int ACLK_NBW = ARISCV_ACLK_NBW,
  parameter int DLY_NBW  = 4,
  parameter int TO_NBW   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic                        i_halt,
  input  logic [DLY_NBW-1:0]          i_dly,
  input  logic [ACLK_NBW-1:0]         i_done,
  output logic [ACLK_NBW-1:0]         o_fire,
  output logic [$clog2(ACLK_NBW)-1:0] o_stage,
  output logic                        o_busy,
  output logic                        o_wrap,
  output logic                        o_err
);
  localparam int SW = $clog2(ACLK_NBW);
  localparam int CW = (TO_NBW > DLY_NBW) ? TO_NBW : DLY_NBW;
  localparam logic [SW-1:0] LAST = SW'(ACLK_NBW - 1);

  ariscv_sched_state_t state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [ACLK_NBW-1:0] fire_q, fire_d;
  logic                pend_q, pend_d;
  logic                wrap_q, wrap_d;
  logic                advance;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic [CW-1:0]       cnt_val;
`ifdef ARISCV_SCHED_TIMEOUT_EN
  logic                err_q, err_d;
`endif

  ariscv_sched_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (cnt_load),
    .i_val  (cnt_val),
    .i_dec  (cnt_dec),
    .o_zero (cnt_zero)
  );

  // next state, stage, halt latch and registered fire/wrap
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    pend_d   = pend_q;
    wrap_d   = 1'b0;
    advance  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
`ifdef ARISCV_SCHED_TIMEOUT_EN
    err_d    = err_q;
`endif
    if (state_q != S_IDLE && i_halt) pend_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_halt) begin
          state_d = S_FIRE;
          stage_d = '0;
          pend_d  = 1'b0;
`ifdef ARISCV_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      S_FIRE: begin
        state_d = S_WAIT;
`ifdef ARISCV_SCHED_TIMEOUT_EN
        cnt_load = 1'b1;
        cnt_val  = CW'((2 ** TO_NBW) - 2);
`endif
      end
      S_WAIT: begin
        if (i_done[stage_q]) begin
          if (i_dly == '0) begin
            advance = 1'b1;
          end else begin
            state_d  = S_SETTLE;
            cnt_load = 1'b1;
            cnt_val  = CW'(i_dly - DLY_NBW'(1));
          end
        end
`ifdef ARISCV_SCHED_TIMEOUT_EN
        else if (cnt_zero) begin
          advance = 1'b1;
          err_d   = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
`endif
      end
      S_SETTLE: begin
        if (cnt_zero) advance = 1'b1;
        else          cnt_dec = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (pend_q || i_halt) begin
        state_d = S_IDLE;
        stage_d = '0;
        pend_d  = 1'b0;
      end else begin
        state_d = S_FIRE;
        wrap_d  = (stage_q == LAST);
        stage_d = (stage_q == LAST) ? '0 : stage_q + SW'(1);
      end
    end
    fire_d = (state_d == S_FIRE) ?
             (ACLK_NBW'(1) << stage_d) : '0;
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      pend_q  <= 1'b0;
      fire_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pend_q  <= pend_d;
      fire_q  <= fire_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef ARISCV_SCHED_TIMEOUT_EN
  // sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_fire  = fire_q;
  assign o_stage = stage_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_wrap  = wrap_q;
endmodule

// File: tb/tb_ariscv_aclk_sched.sv
// Self-checking bench for ariscv_aclk_sched.
// Timeout scenario runs only with ARISCV_SCHED_TIMEOUT_EN.
module tb_ariscv_aclk_sched;
  typedef struct {
    int         cyc;
    logic [5:0] fire;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vec = 0;
  int   errs = 0;
  exp_t sb[$];

  ariscv_aclk_sched_if #(.ACLK_NBW(6), .DLY_NBW(4)) sif ();

  ariscv_aclk_sched #(
    .ACLK_NBW (6),
    .DLY_NBW  (4),
    .TO_NBW   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (sif.start),
    .i_halt  (sif.halt),
    .i_dly   (sif.dly),
    .i_done  (sif.done),
    .o_fire  (sif.fire),
    .o_stage (sif.stage),
    .o_busy  (sif.busy),
    .o_wrap  (sif.wrap),
    .o_err   (sif.err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    sif.start = 1'b0;
    sif.halt  = 1'b0;
    sif.done  = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    sif.start = 1'b1;
    sif.done = '1;
    tick();
    sif.start = 1'b1;
    tick();
    vec++;
    if (sif.fire !== 6'b0 || sif.stage !== 3'd0 || sif.busy !== 1'b0 ||
        sif.wrap !== 1'b0 || sif.err !== 1'b0) begin
      errs++;
      $display("FAIL reset: fire=%b stage=%0d busy=%b wrap=%b err=%b want all 0",
               sif.fire, sif.stage, sif.busy, sif.wrap, sif.err);
    end
    rst = 1'b0;
    tick();
    vec++;
    if (sif.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_release: busy=%b want 0", sif.busy);
    end
    e.cyc = 0;
  endtask

  task automatic test_start();
    exp_t e;
    sif.start = 1'b1;
    sb.push_back('{cyc + 1, 6'b000001, 1'b0});
    tick();
    e = sb.pop_front();
    vec++;
    if (e.cyc != cyc || sif.fire !== e.fire || sif.wrap !== e.wrap) begin
      errs++;
      $display("FAIL start_fire: fire=%b wrap=%b want %b/%b", sif.fire, sif.wrap, e.fire, e.wrap);
    end
    vec++;
    if (sif.busy !== 1'b1 || sif.stage !== 3'd0) begin
      errs++;
      $display("FAIL start_status: busy=%b stage=%0d want 1/0", sif.busy, sif.stage);
    end
    tick();
    vec++;
    if (sif.fire !== 6'b0 || sif.busy !== 1'b1) begin
      errs++;
      $display("FAIL start_wait: fire=%b busy=%b want 0/1", sif.fire, sif.busy);
    end
  endtask

  task automatic test_settle();
    exp_t e;
    sif.dly = 4'd3;
    sif.done = 6'b000001;
    sb.push_back('{cyc + 4, 6'b000010, 1'b0});
    for (int k = 0; k < 5; k++) begin
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        vec++;
        if (sif.fire !== e.fire || sif.wrap !== e.wrap) begin
          errs++;
          $display("FAIL settle_fire: fire=%b wrap=%b want %b/%b", sif.fire, sif.wrap, e.fire, e.wrap);
        end
      end else begin
        vec++;
        if (sif.fire !== 6'b0 || sif.wrap !== 1'b0) begin
          errs++;
          $display("FAIL settle_quiet k=%0d: fire=%b wrap=%b want 0/0", k, sif.fire, sif.wrap);
        end
      end
    end
    sif.dly = 4'd0;
    vec++;
    if (sif.stage !== 3'd1) begin
      errs++;
      $display("FAIL settle_stage: stage=%0d want 1", sif.stage);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [5:0] f;
    for (int s = 1; s < 6; s++) begin
      f = 6'd1 << ((s + 1) % 6);
      sif.done = 6'd1 << s;
      sb.push_back('{cyc + 1, f, (s == 5)});
      tick();
      e = sb.pop_front();
      vec++;
      if (e.cyc != cyc || sif.fire !== e.fire || sif.wrap !== e.wrap) begin
        errs++;
        $display("FAIL wrap_fire s=%0d: fire=%b wrap=%b want %b/%b", s, sif.fire, sif.wrap, e.fire, e.wrap);
      end
      sif.done = '1;
      tick();
      vec++;
      if (sif.fire !== 6'b0 || sif.wrap !== 1'b0 || sif.stage !== 3'((s + 1) % 6)) begin
        errs++;
        $display("FAIL wrap_wait s=%0d: fire=%b wrap=%b stage=%0d want 0/0/%0d",
                 s, sif.fire, sif.wrap, sif.stage, (s + 1) % 6);
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      sif.done = 6'd1 << s;
      sb.push_back('{cyc + 1, 6'd2 << s, 1'b0});
      tick();
      e = sb.pop_front();
      vec++;
      if (e.cyc != cyc || sif.fire !== e.fire || sif.wrap !== e.wrap) begin
        errs++;
        $display("FAIL halt_step s=%0d: fire=%b want %b", s, sif.fire, e.fire);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      sif.done = 6'b111011;
      tick();
      vec++;
      if (sif.fire !== 6'b0 || sif.stage !== 3'd2 || sif.busy !== 1'b1) begin
        errs++;
        $display("FAIL halt_foreign_done k=%0d: fire=%b stage=%0d busy=%b want 0/2/1",
                 k, sif.fire, sif.stage, sif.busy);
      end
    end
    sif.halt = 1'b1;
    tick();
    vec++;
    if (sif.busy !== 1'b1 || sif.fire !== 6'b0) begin
      errs++;
      $display("FAIL halt_pending: busy=%b fire=%b want 1/0", sif.busy, sif.fire);
    end
    sif.done = 6'b000100;
    tick();
    vec++;
    if (sif.busy !== 1'b0 || sif.stage !== 3'd0 || sif.fire !== 6'b0 || sif.wrap !== 1'b0) begin
      errs++;
      $display("FAIL halt_idle: busy=%b stage=%0d fire=%b wrap=%b want 0/0/0/0",
               sif.busy, sif.stage, sif.fire, sif.wrap);
    end
    for (int k = 0; k < 4; k++) begin
      sif.done = '1;
      tick();
      vec++;
      if (sif.fire !== 6'b0 || sif.busy !== 1'b0) begin
        errs++;
        $display("FAIL halt_stays k=%0d: fire=%b busy=%b want 0/0", k, sif.fire, sif.busy);
      end
    end
    sif.start = 1'b1;
    sif.halt = 1'b1;
    tick();
    vec++;
    if (sif.busy !== 1'b0 || sif.fire !== 6'b0) begin
      errs++;
      $display("FAIL start_with_halt: busy=%b fire=%b want 0/0", sif.busy, sif.fire);
    end
  endtask

`ifdef ARISCV_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    sif.start = 1'b1;
    sb.push_back('{cyc + 1, 6'b000001, 1'b0});
    sb.push_back('{cyc + 17, 6'b000010, 1'b0});
    for (int k = 0; k < 17; k++) begin
      tick();
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        vec++;
        if (sif.fire !== e.fire || sif.wrap !== e.wrap) begin
          errs++;
          $display("FAIL timeout_fire: fire=%b wrap=%b want %b/%b", sif.fire, sif.wrap, e.fire, e.wrap);
        end
      end else begin
        vec++;
        if (sif.fire !== 6'b0 || sif.err !== 1'b0) begin
          errs++;
          $display("FAIL timeout_quiet k=%0d: fire=%b err=%b want 0/0", k, sif.fire, sif.err);
        end
      end
    end
    vec++;
    if (sif.err !== 1'b1 || sif.stage !== 3'd1) begin
      errs++;
      $display("FAIL timeout_err: err=%b stage=%0d want 1/1", sif.err, sif.stage);
    end
    sif.halt = 1'b1;
    for (int k = 0; k < 16; k++) tick();
    vec++;
    if (sif.busy !== 1'b0 || sif.err !== 1'b1 || sif.stage !== 3'd0) begin
      errs++;
      $display("FAIL timeout_halt: busy=%b err=%b stage=%0d want 0/1/0", sif.busy, sif.err, sif.stage);
    end
    sif.start = 1'b1;
    tick();
    vec++;
    if (sif.err !== 1'b0 || sif.fire !== 6'b000001) begin
      errs++;
      $display("FAIL timeout_clear: err=%b fire=%b want 0/000001", sif.err, sif.fire);
    end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec++;
    if (sif.fire !== 6'b0 || sif.stage !== 3'd0 || sif.busy !== 1'b0 ||
        sif.wrap !== 1'b0 || sif.err !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_wait: fire=%b stage=%0d busy=%b wrap=%b err=%b want all 0",
               sif.fire, sif.stage, sif.busy, sif.wrap, sif.err);
    end
  endtask
`endif

  initial begin
    sif.start = 1'b0;
    sif.halt  = 1'b0;
    sif.dly   = '0;
    sif.done  = '0;
    test_reset();
    test_start();
    test_settle();
    test_wrap();
    test_halt();
`ifdef ARISCV_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    vec++;
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_leftover: %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
